// File: rtl/part3_mac_pipe.sv
// Signed multiply-accumulate with an optional product register, per-sample
// accumulator clear, output saturation and a sticky saturation flag.
module part3_mac_pipe #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned PIPELINE  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic                        valid_in,
  input  logic                        clear_in,
  output logic signed [ACC_WIDTH-1:0] f,
  output logic                        valid_out,
  output logic                        sat_flag
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned SUM_W  = ACC_WIDTH + 1;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // The accumulator must hold any single product without truncation.
  generate
    if (ACC_WIDTH < PROD_W) begin : g_width_check
      $error("part3_mac_pipe: ACC_WIDTH must be >= 2*WIDTH");
    end
  endgenerate

  logic signed [WIDTH-1:0]  a_r;
  logic signed [WIDTH-1:0]  b_r;
  logic                     clr1;
  logic                     vld1;
  logic signed [PROD_W-1:0] prod_c;

  logic signed [PROD_W-1:0] acc_p;
  logic                     acc_vld;
  logic                     acc_clr;

  logic signed [SUM_W-1:0]     base_c;
  logic signed [SUM_W-1:0]     sum_c;
  logic                        ovf_c;
  logic signed [ACC_WIDTH-1:0] f_next_c;

  // Operand capture: operands hold while no sample is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r  <= '0;
      b_r  <= '0;
      clr1 <= 1'b0;
      vld1 <= 1'b0;
    end else begin
      vld1 <= valid_in;
      if (valid_in) begin
        a_r  <= a;
        b_r  <= b;
        clr1 <= clear_in;
      end
    end
  end

  // Full-precision signed product of the captured operands.
  always_comb begin
    prod_c = PROD_W'(a_r) * PROD_W'(b_r);
  end

  generate
    if (PIPELINE != 0) begin : g_pipe
      logic signed [PROD_W-1:0] p_r;
      logic                     vld2;
      logic                     clr2;

      // Product register stage carrying its own valid/clear bits.
      always_ff @(posedge clk) begin
        if (reset) begin
          p_r  <= '0;
          vld2 <= 1'b0;
          clr2 <= 1'b0;
        end else begin
          vld2 <= vld1;
          if (vld1) begin
            p_r  <= prod_c;
            clr2 <= clr1;
          end
        end
      end

      assign acc_p   = p_r;
      assign acc_vld = vld2;
      assign acc_clr = clr2;
    end else begin : g_comb
      assign acc_p   = prod_c;
      assign acc_vld = vld1;
      assign acc_clr = clr1;
    end
  endgenerate

  // Wide sum with one guard bit; disagreeing top bits mean the result left range.
  always_comb begin
    base_c   = acc_clr ? '0 : SUM_W'(f);
    sum_c    = SUM_W'(acc_p) + base_c;
    ovf_c    = (sum_c[ACC_WIDTH] != sum_c[ACC_WIDTH-1]);
    f_next_c = sum_c[ACC_WIDTH-1:0];
    if (ovf_c) begin
      f_next_c = sum_c[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  // Accumulator, output strobe and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      f         <= '0;
      valid_out <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      valid_out <= acc_vld;
      if (acc_vld) begin
        f        <= f_next_c;
        sat_flag <= (acc_clr ? 1'b0 : sat_flag) | ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_part3_mac_pipe.sv
// Directed bench for part3_mac_pipe: default core plus a PIPELINE=1 copy for latency.
module tb_part3_mac_pipe;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [9:0] a;
  logic signed [9:0] b;
  logic              valid_in;
  logic              clear_in;
  logic signed [19:0] f;
  logic              valid_out;
  logic              sat_flag;
  logic signed [19:0] f_p;
  logic              valid_out_p;
  logic              sat_flag_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  part3_mac_pipe #(.WIDTH(10), .ACC_WIDTH(20), .PIPELINE(0)) u_dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
    .f(f), .valid_out(valid_out), .sat_flag(sat_flag)
  );

  part3_mac_pipe #(.WIDTH(10), .ACC_WIDTH(20), .PIPELINE(1)) u_dut_p (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_in(clear_in),
    .f(f_p), .valid_out(valid_out_p), .sat_flag(sat_flag_p)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic c, input int av, input int bv);
    valid_in = v;
    clear_in = c;
    a        = 10'(av);
    b        = 10'(bv);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    tick(); tick();
    check("rst_f", f, 0);
    check("rst_valid", valid_out, 0);
    check("rst_sat", sat_flag, 0);
    reset = 1'b0;

    // 1: single sample, latency 2 (and 3 on the pipelined copy)
    drive(1, 0, 3, 4); tick();
    drive(0, 0, 0, 0);
    check("t1_not_early", valid_out, 0);
    tick();
    check("t1_valid", valid_out, 1);
    check("t1_f", f, 12);
    check("t1_sat", sat_flag, 0);
    check("t1p_not_early", valid_out_p, 0);
    tick();
    check("t1_pulse_end", valid_out, 0);
    check("t1p_valid", valid_out_p, 1);
    check("t1p_f", f_p, 12);
    check("t1p_sat", sat_flag_p, 0);

    // 2: back-to-back positive saturation, then stays clamped
    drive(1, 1, 511, 511); tick();
    drive(1, 0, 511, 511); tick();
    check("t2_f1", f, 261121);
    check("t2_v1", valid_out, 1);
    drive(1, 0, 511, 511); tick();
    check("t2_f2", f, 522242);
    check("t2_sat2", sat_flag, 0);
    drive(1, 0, 511, 511); tick();
    check("t2_f3", f, 524287);
    check("t2_sat3", sat_flag, 1);
    drive(0, 0, 0, 0); tick();
    check("t2_f4_clamp", f, 524287);
    check("t2_v4", valid_out, 1);
    check("t2_sat4", sat_flag, 1);
    tick();
    check("t2_idle", valid_out, 0);

    // 4: clear applies to its own sample and clears the sticky flag
    drive(1, 1, 2, 5); tick();
    drive(1, 0, 1, 1); tick();
    check("t4_f_clr", f, 10);
    check("t4_sat_clr", sat_flag, 0);
    drive(0, 0, 0, 0); tick();
    check("t4_f_next", f, 11);
    check("t4_v_next", valid_out, 1);

    // 3: negative saturation from reset, then pulled back in range
    reset = 1'b1; tick();
    reset = 1'b0;
    check("t3_rst_f", f, 0);
    drive(1, 0, -512, 511); tick();
    drive(1, 0, -512, 511); tick();
    check("t3_f1", f, -261632);
    drive(1, 0, -512, 511); tick();
    check("t3_f2", f, -523264);
    drive(1, 0, -512, -512); tick();
    check("t3_f3", f, -524288);
    check("t3_sat3", sat_flag, 1);
    drive(0, 0, 0, 0); tick();
    check("t3_f4", f, -262144);
    check("t3_sat4", sat_flag, 1);

    // 5: valid pattern 1,0,0,1; clear_in during gaps must be ignored
    drive(1, 1, 10, 10); tick();
    drive(0, 1, 10, 10); tick();
    drive(0, 1, 10, 10);
    check("t5_v1", valid_out, 1);
    check("t5_f1", f, 100);
    check("t5_sat", sat_flag, 0);
    tick();
    drive(1, 0, 10, 10);
    check("t5_gap1_v", valid_out, 0);
    check("t5_gap1_f", f, 100);
    tick();
    drive(0, 0, 0, 0);
    check("t5_gap2_v", valid_out, 0);
    check("t5_gap2_f", f, 100);
    tick();
    check("t5_v2", valid_out, 1);
    check("t5_f2", f, 200);
    tick();
    check("t5_end_v", valid_out, 0);
    check("t5_end_f", f, 200);

    // 6: reset with samples in flight (second sample coincides with reset)
    drive(1, 0, 511, 511); tick();
    drive(1, 0, 511, 511);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0);
    check("t6_rst_f", f, 0);
    check("t6_rst_v", valid_out, 0);
    check("t6_rst_sat", sat_flag, 0);
    tick();
    check("t6_drop_v1", valid_out, 0);
    tick();
    check("t6_drop_v2", valid_out, 0);
    check("t6_drop_f", f, 0);
    drive(1, 0, 7, -3); tick();
    drive(0, 0, 0, 0); tick();
    check("t6_f", f, -21);
    check("t6_v", valid_out, 1);
    check("t6_sat", sat_flag, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
